dcache_port_arb: RTL and testbench



---
 rtl/dcache_port_arb_pkg.sv | 29 ++
 rtl/dcache_arb_src_fifo.sv | 53 +++++
 rtl/dcache_port_arb.sv | 174 +++++++++++++++++
 tb/tb_dcache_port_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | dcache_port_arb_pkg: shared source IDs and request-field widths.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package dcache_port_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 11;
    localparam int STRB_W = 4;

    localparam logic DCACHE_ARB_M0 = 1'b0;
    localparam logic DCACHE_ARB_M1 = 1'b1;

    function automatic logic req_valid(
        input logic              rd,
        input logic [STRB_W-1:0] wr,
        input logic              flush,
        input logic              invalidate,
        input logic              writeback
    );
        return rd | (|wr) | flush | invalidate | writeback;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_arb_src_fifo.sv
// +--------------------------------------------------------------------------+
// | dcache_arb_src_fifo: DEPTH x 1-bit in-order source-ID queue.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dcache_arb_src_fifo #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             push_data_i,
    input  logic             pop_i,
    output logic [DEPTH_W:0] count_o,
    output logic             head_o
);

    logic [DEPTH-1:0]   mem_q;
    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [DEPTH_W:0]   count_q;

    // Pointers are exactly DEPTH_W bits, so wrap-around is the natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/dcache_port_arb.sv
// +--------------------------------------------------------------------------+
// | dcache_port_arb: two-master arbiter for the data-cache request port.     |
// | Optional round-robin priority via macro DCACHE_ARB_RR_EN. Revision: 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dcache_port_arb
    import dcache_port_arb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic        m0_cacheable_i,
    input  logic [10:0] m0_req_tag_i,
    input  logic        m0_invalidate_i,
    input  logic        m0_writeback_i,
    input  logic        m0_flush_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [31:0] m0_data_rd_o,
    output logic [10:0] m0_resp_tag_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic        m1_cacheable_i,
    input  logic [10:0] m1_req_tag_i,
    input  logic        m1_invalidate_i,
    input  logic        m1_writeback_i,
    input  logic        m1_flush_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_rd_o,
    output logic [10:0] m1_resp_tag_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic        mem_cacheable_o,
    output logic [10:0] mem_req_tag_o,
    output logic        mem_invalidate_o,
    output logic        mem_writeback_o,
    output logic        mem_flush_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic [10:0] mem_resp_tag_i,
    output logic        busy_o,
    output logic        unexp_ack_o
);

    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    logic             req0_w;
    logic             req1_w;
    logic             pref_w;
    logic             gnt_w;
    logic             gnt_req_w;
    logic             stall_w;
    logic             accept_w;
    logic             pop_w;
    logic             head_w;
    logic [DEPTH_W:0] count_w;
    logic             lock_q;
    logic             gnt_q;
    logic             unexp_q;

    assign req0_w = req_valid(m0_rd_i, m0_wr_i, m0_flush_i, m0_invalidate_i, m0_writeback_i);
    assign req1_w = req_valid(m1_rd_i, m1_wr_i, m1_flush_i, m1_invalidate_i, m1_writeback_i);

`ifdef DCACHE_ARB_RR_EN
    logic rr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= DCACHE_ARB_M0;
        end else if (accept_w && (gnt_w == rr_q)) begin
            rr_q <= ~rr_q;
        end
    end

    assign pref_w = rr_q;
`else
    assign pref_w = DCACHE_ARB_M0;
`endif

    always_comb begin
        gnt_w = DCACHE_ARB_M0;
        if (lock_q) begin
            gnt_w = gnt_q;
        end else if (req0_w && !req1_w) begin
            gnt_w = DCACHE_ARB_M0;
        end else if (req1_w && !req0_w) begin
            gnt_w = DCACHE_ARB_M1;
        end else if (req0_w && req1_w) begin
            gnt_w = pref_w;
        end
    end

    // A same-cycle ack frees a slot, so a full queue only stalls without one.
    assign stall_w   = (count_w == FULL_CNT) && !mem_ack_i;
    assign gnt_req_w = gnt_w ? req1_w : req0_w;
    assign accept_w  = gnt_req_w && mem_accept_i && !stall_w;
    assign pop_w     = mem_ack_i && (count_w != '0);

    assign m0_accept_o = accept_w && (gnt_w == DCACHE_ARB_M0);
    assign m1_accept_o = accept_w && (gnt_w == DCACHE_ARB_M1);

    assign mem_addr_o       = gnt_w ? m1_addr_i      : m0_addr_i;
    assign mem_data_wr_o    = gnt_w ? m1_data_wr_i   : m0_data_wr_i;
    assign mem_cacheable_o  = gnt_w ? m1_cacheable_i : m0_cacheable_i;
    assign mem_req_tag_o    = gnt_w ? m1_req_tag_i   : m0_req_tag_i;
    assign mem_rd_o         = !stall_w && (gnt_w ? m1_rd_i         : m0_rd_i);
    assign mem_wr_o         = stall_w ? 4'h0 : (gnt_w ? m1_wr_i : m0_wr_i);
    assign mem_invalidate_o = !stall_w && (gnt_w ? m1_invalidate_i : m0_invalidate_i);
    assign mem_writeback_o  = !stall_w && (gnt_w ? m1_writeback_i  : m0_writeback_i);
    assign mem_flush_o      = !stall_w && (gnt_w ? m1_flush_i      : m0_flush_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q  <= 1'b0;
            gnt_q   <= DCACHE_ARB_M0;
            unexp_q <= 1'b0;
        end else begin
            if (lock_q) begin
                if (accept_w || !gnt_req_w) begin
                    lock_q <= 1'b0;
                end
            end else if (gnt_req_w && !stall_w && !mem_accept_i) begin
                lock_q <= 1'b1;
                gnt_q  <= gnt_w;
            end
            if (mem_ack_i && (count_w == '0)) begin
                unexp_q <= 1'b1;
            end
        end
    end

    dcache_arb_src_fifo #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_src_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept_w),
        .push_data_i (gnt_w),
        .pop_i       (pop_w),
        .count_o     (count_w),
        .head_o      (head_w)
    );

    assign m0_ack_o      = pop_w && (head_w == DCACHE_ARB_M0);
    assign m1_ack_o      = pop_w && (head_w == DCACHE_ARB_M1);
    assign m0_error_o    = mem_error_i;
    assign m1_error_o    = mem_error_i;
    assign m0_data_rd_o  = mem_data_rd_i;
    assign m1_data_rd_o  = mem_data_rd_i;
    assign m0_resp_tag_o = mem_resp_tag_i;
    assign m1_resp_tag_o = mem_resp_tag_i;
    assign busy_o        = (count_w != '0);
    assign unexp_ack_o   = unexp_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arb.sv
// +--------------------------------------------------------------------------+
// | tb_dcache_port_arb: directed scoreboard bench for dcache_port_arb.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_port_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
    logic        m0_rd_i, m0_cacheable_i, m0_invalidate_i, m0_writeback_i, m0_flush_i;
    logic        m1_rd_i, m1_cacheable_i, m1_invalidate_i, m1_writeback_i, m1_flush_i;
    logic [3:0]  m0_wr_i, m1_wr_i;
    logic [10:0] m0_req_tag_i, m1_req_tag_i;
    logic        m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o;
    logic [31:0] m0_data_rd_o, m1_data_rd_o;
    logic [10:0] m0_resp_tag_o, m1_resp_tag_o;
    logic [31:0] mem_addr_o, mem_data_wr_o;
    logic        mem_rd_o, mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o;
    logic [3:0]  mem_wr_o;
    logic [10:0] mem_req_tag_o;
    logic        mem_accept_i, mem_ack_i, mem_error_i;
    logic [31:0] mem_data_rd_i;
    logic [10:0] mem_resp_tag_i;
    logic        busy_o, unexp_ack_o;

    int   n_cmp = 0;
    int   n_err = 0;
    logic sb[$];
    logic pref = 1'b0;

    dcache_port_arb #(.DEPTH(4), .DEPTH_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i),
        .m0_wr_i(m0_wr_i), .m0_cacheable_i(m0_cacheable_i), .m0_req_tag_i(m0_req_tag_i),
        .m0_invalidate_i(m0_invalidate_i), .m0_writeback_i(m0_writeback_i),
        .m0_flush_i(m0_flush_i), .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o),
        .m0_error_o(m0_error_o), .m0_data_rd_o(m0_data_rd_o), .m0_resp_tag_o(m0_resp_tag_o),
        .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i),
        .m1_wr_i(m1_wr_i), .m1_cacheable_i(m1_cacheable_i), .m1_req_tag_i(m1_req_tag_i),
        .m1_invalidate_i(m1_invalidate_i), .m1_writeback_i(m1_writeback_i),
        .m1_flush_i(m1_flush_i), .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o),
        .m1_error_o(m1_error_o), .m1_data_rd_o(m1_data_rd_o), .m1_resp_tag_o(m1_resp_tag_o),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_cacheable_o(mem_cacheable_o), .mem_req_tag_o(mem_req_tag_o),
        .mem_invalidate_o(mem_invalidate_o), .mem_writeback_o(mem_writeback_o),
        .mem_flush_o(mem_flush_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
        .mem_error_i(mem_error_i), .mem_data_rd_i(mem_data_rd_i),
        .mem_resp_tag_i(mem_resp_tag_i), .busy_o(busy_o), .unexp_ack_o(unexp_ack_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clr_req();
        m0_rd_i = 0; m0_wr_i = 0; m0_invalidate_i = 0; m0_writeback_i = 0; m0_flush_i = 0;
        m1_rd_i = 0; m1_wr_i = 0; m1_invalidate_i = 0; m1_writeback_i = 0; m1_flush_i = 0;
    endtask

    // Expected accept bookkeeping: queue the source, advance the round-robin model.
    task automatic note_accept(input logic m);
        sb.push_back(m);
`ifdef DCACHE_ARB_RR_EN
        if (m == pref) pref = ~pref;
`endif
    endtask

    // Called with mem_ack_i already driven high and settled.
    task automatic ack_chk(input string tag);
        logic e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_m0_ack"}, m0_ack_o, e == 1'b0);
            chk({tag, "_m1_ack"}, m1_ack_o, e == 1'b1);
        end
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0) begin
            mem_ack_i = 1;
            settle();
            ack_chk(tag);
            tick();
        end
        mem_ack_i = 0;
    endtask

    task automatic single(input logic m, input logic [31:0] addr);
        if (m) begin m1_rd_i = 1; m1_addr_i = addr; end
        else   begin m0_rd_i = 1; m0_addr_i = addr; end
        settle();
        chk("single_m0_acc", m0_accept_o, m == 1'b0);
        chk("single_m1_acc", m1_accept_o, m == 1'b1);
        chk("single_addr", mem_addr_o, addr);
        note_accept(m);
        tick();
        clr_req();
    endtask

    initial begin
        logic w;
        rst_i = 1;
        clr_req();
        m0_addr_i = 0; m0_data_wr_i = 32'hA0A0_0000; m0_cacheable_i = 1; m0_req_tag_i = 0;
        m1_addr_i = 0; m1_data_wr_i = 32'hB1B1_0000; m1_cacheable_i = 0; m1_req_tag_i = 0;
        mem_accept_i = 0; mem_ack_i = 0; mem_error_i = 0;
        mem_data_rd_i = 32'hDEAD_BEEF; mem_resp_tag_i = 0;
        tick(); tick();
        rst_i = 0;
        settle();
        chk("rst_busy", busy_o, 0);
        chk("rst_unexp", unexp_ack_o, 0);
        chk("rst_m0_acc", m0_accept_o, 0);
        chk("rst_m0_ack", m0_ack_o, 0);
        tick();

        // Single m0 read, ack three cycles later.
        mem_accept_i = 1;
        m0_rd_i = 1; m0_addr_i = 32'h1000; m0_req_tag_i = 11'h005;
        settle();
        chk("t1_m0_acc", m0_accept_o, 1);
        chk("t1_m1_acc", m1_accept_o, 0);
        chk("t1_mem_rd", mem_rd_o, 1);
        chk("t1_addr", mem_addr_o, 32'h1000);
        chk("t1_tag", mem_req_tag_o, 11'h005);
        note_accept(1'b0);
        tick();
        clr_req();
        settle();
        chk("t1_busy", busy_o, 1);
        tick(); tick();
        mem_ack_i = 1; mem_resp_tag_i = 11'h005; mem_data_rd_i = 32'h1234_5678;
        settle();
        chk("t1_resp_tag", m0_resp_tag_o, 11'h005);
        chk("t1_data", m0_data_rd_o, 32'h1234_5678);
        ack_chk("t1");
        tick();
        mem_ack_i = 0;
        settle();
        chk("t1_idle", busy_o, 0);
        tick();

        // Simultaneous requests: winner first, loser next cycle.
        m0_rd_i = 1; m0_addr_i = 32'h2000;
        m1_rd_i = 1; m1_addr_i = 32'h2100;
        w = pref;
        settle();
        chk("t2_m0_acc", m0_accept_o, w == 1'b0);
        chk("t2_m1_acc", m1_accept_o, w == 1'b1);
        note_accept(w);
        tick();
        if (w) m1_rd_i = 0; else m0_rd_i = 0;
        settle();
        chk("t2b_m0_acc", m0_accept_o, w == 1'b1);
        chk("t2b_m1_acc", m1_accept_o, w == 1'b0);
        note_accept(~w);
        tick();
        clr_req();
        drain("t2");

        // Four back-to-back dual requests follow the priority model.
        for (int i = 0; i < 4; i++) begin
            m0_rd_i = 1; m0_addr_i = 32'h3000 + i;
            m1_rd_i = 1; m1_addr_i = 32'h3100 + i;
            w = pref;
            settle();
            chk("t3_m0_acc", m0_accept_o, w == 1'b0);
            chk("t3_m1_acc", m1_accept_o, w == 1'b1);
            note_accept(w);
            tick();
        end
        clr_req();
        drain("t3");

        // Stalled m1 write holds the grant while m0 waits.
        mem_accept_i = 0;
        m1_wr_i = 4'hF; m1_addr_i = 32'h4000;
        settle();
        chk("t4_addr0", mem_addr_o, 32'h4000);
        chk("t4_m1_acc0", m1_accept_o, 0);
        tick();
        m0_rd_i = 1; m0_addr_i = 32'h4100;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t4_addr_hold", mem_addr_o, 32'h4000);
            chk("t4_wr_hold", mem_wr_o, 4'hF);
            chk("t4_m0_acc_hold", m0_accept_o, 0);
            tick();
        end
        mem_accept_i = 1;
        settle();
        chk("t4_m1_acc", m1_accept_o, 1);
        chk("t4_m0_acc", m0_accept_o, 0);
        note_accept(1'b1);
        tick();
        m1_wr_i = 0;
        settle();
        chk("t4_addr_m0", mem_addr_o, 32'h4100);
        chk("t4_m0_acc2", m0_accept_o, 1);
        note_accept(1'b0);
        tick();
        clr_req();
        drain("t4");

        // Fill the queue, block the fifth, release it with a same-cycle ack.
        single(1'b0, 32'h5000);
        single(1'b1, 32'h5001);
        single(1'b1, 32'h5002);
        single(1'b0, 32'h5003);
        m1_rd_i = 1; m1_addr_i = 32'h5004;
        settle();
        chk("t5_busy", busy_o, 1);
        chk("t5_blocked_rd", mem_rd_o, 0);
        chk("t5_blocked_acc", m1_accept_o, 0);
        tick();
        mem_ack_i = 1;
        settle();
        chk("t5_unblock_rd", mem_rd_o, 1);
        chk("t5_unblock_acc", m1_accept_o, 1);
        ack_chk("t5_head");
        note_accept(1'b1);
        tick();
        clr_req();
        mem_ack_i = 0;
        drain("t5");

        // Ack with nothing outstanding is dropped and flagged.
        mem_ack_i = 1;
        settle();
        chk("t6_m0_ack", m0_ack_o, 0);
        chk("t6_m1_ack", m1_ack_o, 0);
        tick();
        mem_ack_i = 0;
        settle();
        chk("t6_unexp", unexp_ack_o, 1);
        tick();
        settle();
        chk("t6_unexp_hold", unexp_ack_o, 1);
        tick();

        // Asynchronous reset with two requests outstanding.
        single(1'b0, 32'h6000);
        single(1'b1, 32'h6001);
        #2;
        rst_i = 1;
        #1;
        chk("t7_rst_busy", busy_o, 0);
        chk("t7_rst_unexp", unexp_ack_o, 0);
        #1;
        rst_i = 0;
        sb.delete();
        pref = 1'b0;
        tick();
        single(1'b0, 32'h6100);
        drain("t7_new");
        settle();
        chk("t7_no_unexp", unexp_ack_o, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_ack_i = 1;
            settle();
            chk("t7_stale_m0_ack", m0_ack_o, 0);
            chk("t7_stale_m1_ack", m1_ack_o, 0);
            tick();
        end
        mem_ack_i = 0;
        settle();
        chk("t7_stale_unexp", unexp_ack_o, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
